sketch_counter_dump: RTL and testbench
======================================

Name: sketch_counter_dump

Overview:
Upstream feeder for the tower encoding pipeline. Holds an array of NUM_COUNTER saturating sketch counters that are incremented by the measurement front end. On command, it streams the whole array, one counter per clock, into the sparse/threshold stage in index order. Each counter is cleared as it is read, so the next measurement epoch starts from zero without a separate clear pass.

Parameters:
NUM_COUNTER, 10, number of counters in the array; must be ≥ 2
WIDTH, 32, counter width in bits; matches the encoder's 32-bit counter input
IDX_W, 4, index width; must satisfy 2^IDX_W ≥ NUM_COUNTER

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Inc_Valid  in  1  increment request this cycle
Inc_Index  in  IDX_W  counter to increment
Inc_Value  in  WIDTH  amount to add
Dump_Start  in  1  single-cycle pulse: begin streaming the array
Counter  out  WIDTH  streamed counter value; drives the encoder's Counter input
Counter_Valid  out  1  Counter holds a valid array element
Frame_Last  out  1  high together with the final element (index NUM_COUNTER-1)
Busy  out  1  dump in progress
Inc_Dropped  out  1  one-cycle pulse: increment rejected because Inc_Index ≥ NUM_COUNTER

Behaviour:
- Reset is synchronous. On reset, all counters, Counter, Counter_Valid, Frame_Last, Busy and Inc_Dropped go to 0, the read pointer goes to 0, and the FSM goes to IDLE.
- Reset asserted mid-dump aborts the frame immediately. No Frame_Last is produced.
- FSM states: IDLE and DUMP.
  - IDLE -> DUMP when Dump_Start=1. The pointer is set to 0.
  - DUMP -> IDLE on the cycle after the element at pointer NUM_COUNTER-1 is issued.
- Dump_Start is ignored while in DUMP. It does not queue and does not restart the frame.
- Increment: when Inc_Valid=1 and Inc_Index < NUM_COUNTER, the counter becomes min(counter + Inc_Value, 2^WIDTH-1).
  - The addition is done at WIDTH+1 bits and saturates; it never wraps.
  - Increments are accepted in both IDLE and DUMP.
- Out-of-range index: no counter changes, and Inc_Dropped=1 on the next cycle.
- Dump timing: Dump_Start sampled high at edge t gives the first element (index 0) registered at edge t+1. Index k appears at edge t+1+k with Counter_Valid=1. Frame_Last=1 only at index NUM_COUNTER-1.
  - Frame length is exactly NUM_COUNTER consecutive valid cycles, with no bubbles.
  - Busy is 1 from edge t+1 through the last element, and 0 the cycle after.
- Read-and-clear: in the cycle element p is read, counter p is cleared to 0 unless a same-cycle increment targets p (see collisions).
- Collision rules, evaluated in the same cycle:
  - Increment targets the element being read (index = pointer): the streamed value excludes the increment, and the counter is loaded with min(Inc_Value, max) instead of 0.
  - Increment targets an index > pointer (not yet dumped): it is applied and included in this frame.
  - Increment targets an index < pointer (already dumped): it is applied to the new epoch.
  - Dump_Start and Inc_Valid together in IDLE: the increment is applied first and is included in the frame.
- When Counter_Valid=0, Counter is driven to 0, so downstream threshold logic sees 0 between frames.
- The output has no backpressure. The consumer must accept one element per cycle.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

Test Plan:
- Reset, then Dump_Start with no increments -> 10 cycles of Counter=0 with Counter_Valid=1, Frame_Last only on cycle 10, Busy=1 for exactly 10 cycles.
- Increments idx3 += 25, idx3 += 5, idx9 += 1, then Dump_Start -> stream 0,0,0,30,0,0,0,0,0,1. A second dump streams all zeros (clear verified).
- idx0 += 0xFFFFFFF0 then idx0 += 0x20 -> idx0 dumps as 0xFFFFFFFF (saturated, no wrap).
- During a dump, at the cycle the pointer is at 4, apply idx4 += 7, idx2 += 3 and idx8 += 2 on consecutive cycles. Expected: frame shows old idx4 value and idx8 including +2. The next dump shows idx4=7, idx2=3, idx8=0.
- Dump_Start re-pulsed mid-frame, then Inc_Index=12 -> frame length unchanged at 10, no second frame starts, and Inc_Dropped pulses for 1 cycle with no counter changed.
- Reset asserted at frame element 5 -> on the next cycle all outputs are 0 and Busy=0. A subsequent dump streams all zeros.

Source files
------------

// File: rtl/sketch_counter_dump.sv
// sketch_counter_dump
// Array of saturating sketch counters fed by the measurement front end.
// On a Dump_Start pulse the whole array is streamed out, one element per
// clock in index order, and each element is cleared as it is read so the
// next measurement epoch starts from zero without a separate clear pass.
// Parameter constraints: NUM_COUNTER >= 2 and 2**IDX_W >= NUM_COUNTER.

module sketch_counter_dump #(
   parameter int NUM_COUNTER = 10,
   parameter int WIDTH       = 32,
   parameter int IDX_W       = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Inc_Valid,
   input  logic [IDX_W-1:0] Inc_Index,
   input  logic [WIDTH-1:0] Inc_Value,
   input  logic             Dump_Start,
   output logic [WIDTH-1:0] Counter,
   output logic             Counter_Valid,
   output logic             Frame_Last,
   output logic             Busy,
   output logic             Inc_Dropped
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_DUMP = 1'b1
   } state_t;

   // Range limit widened by one bit so the compare also works when the
   // array fills the whole index space.
   localparam logic [IDX_W:0]   NUM_COUNTER_EXT = (IDX_W+1)'(NUM_COUNTER);
   localparam logic [IDX_W-1:0] LAST_IDX        = IDX_W'(NUM_COUNTER - 1);
   localparam logic [WIDTH-1:0] CNT_MAX         = {WIDTH{1'b1}};

   // Add at WIDTH+1 bits and clamp to the all-ones value instead of wrapping.
   function automatic logic [WIDTH-1:0] sat_add(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[WIDTH]) begin
         sat_add = CNT_MAX;
      end else begin
         sat_add = sum[WIDTH-1:0];
      end
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t           state_r;
   state_t           state_next_s;
   logic [IDX_W-1:0] ptr_r;
   logic [IDX_W-1:0] ptr_next_s;
   logic [WIDTH-1:0] cnt_r      [NUM_COUNTER];
   logic [WIDTH-1:0] cnt_next_s [NUM_COUNTER];

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   logic                   inc_in_range_s;
   logic                   inc_hit_s;
   logic                   read_en_s;
   logic [WIDTH-1:0]       read_val_s;
   logic [NUM_COUNTER-1:0] clr_sel_s;
   logic [NUM_COUNTER-1:0] inc_sel_s;

   logic [WIDTH-1:0]       counter_next_s;
   logic                   valid_next_s;
   logic                   last_next_s;
   logic                   busy_next_s;
   logic                   dropped_next_s;

   // Classify the incoming increment: accepted or dropped as out of range.
   always_comb begin
      inc_in_range_s = ({1'b0, Inc_Index} < NUM_COUNTER_EXT);
      inc_hit_s      = Inc_Valid & inc_in_range_s;
      dropped_next_s = Inc_Valid & ~inc_in_range_s;
   end

   // Select the element under the read pointer.
   always_comb begin
      read_val_s = '0;
      for (int i = 0; i < NUM_COUNTER; i++) begin
         read_val_s = (ptr_r == IDX_W'(i)) ? cnt_r[i] : read_val_s;
      end
   end

   // FSM next state, pointer advance and next values of the output stage.
   always_comb begin
      state_next_s   = state_r;
      ptr_next_s     = ptr_r;
      read_en_s      = 1'b0;
      counter_next_s = '0;
      valid_next_s   = 1'b0;
      last_next_s    = 1'b0;
      busy_next_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (Dump_Start) begin
               state_next_s = ST_DUMP;
               ptr_next_s   = '0;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_DUMP: begin
            // Dump_Start is deliberately not looked at here: a pulse during
            // a frame neither queues nor restarts it.
            read_en_s      = 1'b1;
            counter_next_s = read_val_s;
            valid_next_s   = 1'b1;
            busy_next_s    = 1'b1;
            if (ptr_r == LAST_IDX) begin
               last_next_s  = 1'b1;
               state_next_s = ST_IDLE;
               ptr_next_s   = '0;
            end else begin
               ptr_next_s   = ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            ptr_next_s   = '0;
         end
      endcase
   end

   // Per-counter one-hot selects for the read-clear and the increment.
   always_comb begin
      clr_sel_s = '0;
      inc_sel_s = '0;
      for (int i = 0; i < NUM_COUNTER; i++) begin
         clr_sel_s[i] = read_en_s & (ptr_r == IDX_W'(i));
         inc_sel_s[i] = inc_hit_s & (Inc_Index == IDX_W'(i));
      end
   end

   // Next counter values: clear on read first, then apply the increment on
   // top. A same-cycle increment on the element being read therefore lands
   // on zero (new epoch) while the streamed value keeps the old contents.
   always_comb begin
      for (int i = 0; i < NUM_COUNTER; i++) begin
         cnt_next_s[i] = clr_sel_s[i] ? '0 : cnt_r[i];
         cnt_next_s[i] = inc_sel_s[i] ? sat_add(cnt_next_s[i], Inc_Value)
                                      : cnt_next_s[i];
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------

   // FSM state and read pointer; reset aborts any frame in progress.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= ST_IDLE;
         ptr_r   <= '0;
      end else begin
         state_r <= state_next_s;
         ptr_r   <= ptr_next_s;
      end
   end

   // Counter array storage.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_COUNTER; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_COUNTER; i++) begin
            cnt_r[i] <= cnt_next_s[i];
         end
      end
   end

   // Output stage: streamed element (zero between frames), framing flags
   // and the drop pulse, all driven straight from flops.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Counter       <= '0;
         Counter_Valid <= 1'b0;
         Frame_Last    <= 1'b0;
         Busy          <= 1'b0;
         Inc_Dropped   <= 1'b0;
      end else begin
         Counter       <= counter_next_s;
         Counter_Valid <= valid_next_s;
         Frame_Last    <= last_next_s;
         Busy          <= busy_next_s;
         Inc_Dropped   <= dropped_next_s;
      end
   end

endmodule

// File: tb/tb_sketch_counter_dump.sv
// Self-checking bench for sketch_counter_dump: a table of hand-derived
// vectors, hand-written multi-cycle sequences and a randomized phase, all
// also compared every cycle against an epoch/frame-level reference model.

module tb_sketch_counter_dump;

   localparam int N = 10;
   localparam int W = 32;
   localparam longint MAXV = 64'd4294967295;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Inc_Valid;
   logic [3:0]    Inc_Index;
   logic [W-1:0]  Inc_Value;
   logic          Dump_Start;
   logic [W-1:0]  Counter;
   logic          Counter_Valid;
   logic          Frame_Last;
   logic          Busy;
   logic          Inc_Dropped;

   int tests = 0;
   int fails = 0;

   sketch_counter_dump #(.NUM_COUNTER(N), .WIDTH(W), .IDX_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .Inc_Valid(Inc_Valid), .Inc_Index(Inc_Index),
      .Inc_Value(Inc_Value), .Dump_Start(Dump_Start), .Counter(Counter),
      .Counter_Valid(Counter_Valid), .Frame_Last(Frame_Last), .Busy(Busy),
      .Inc_Dropped(Inc_Dropped)
   );

   always #5 Clk = ~Clk;

   // ---------------- reference model ----------------
   // Counters as plain integers; a frame is described only by the edge at
   // which Dump_Start was accepted (element k is emitted k+1 edges later).
   longint      mdl [N];
   int          cyc   = 0;
   int          frm_s = -1000;
   logic [31:0] m_cnt;
   bit          m_val, m_last, m_busy, m_drop;

   task automatic model_edge(input bit rst, input bit iv, input int ii,
                             input logic [31:0] ival, input bit ds);
      int     k;
      bit     in_frame;
      longint v;
      k = cyc - frm_s - 1;
      m_cnt = '0; m_val = 0; m_last = 0; m_busy = 0; m_drop = 0;
      if (rst) begin
         for (int i = 0; i < N; i++) mdl[i] = 0;
         frm_s = -1000;
      end else begin
         in_frame = (k >= 0) && (k < N);
         if (in_frame) begin
            m_val  = 1;
            m_busy = 1;
            m_cnt  = mdl[k][31:0];
            m_last = (k == N - 1);
            mdl[k] = 0;
         end
         if (iv) begin
            if (ii < N) begin
               v = mdl[ii] + {32'd0, ival};
               mdl[ii] = (v > MAXV) ? MAXV : v;
            end else begin
               m_drop = 1;
            end
         end
         if (ds && !in_frame) frm_s = cyc;
      end
      cyc++;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, clock it, advance the model, compare.
   task automatic step(input bit rst, input bit iv, input int ii,
                       input logic [31:0] ival, input bit ds);
      Reset = rst; Inc_Valid = iv; Inc_Index = 4'(ii); Inc_Value = ival; Dump_Start = ds;
      @(posedge Clk);
      model_edge(rst, iv, ii, ival, ds);
      #1;
      chk("mdl_counter", {32'd0, Counter}, {32'd0, m_cnt});
      chk("mdl_valid",   {63'd0, Counter_Valid}, {63'd0, m_val});
      chk("mdl_last",    {63'd0, Frame_Last}, {63'd0, m_last});
      chk("mdl_busy",    {63'd0, Busy}, {63'd0, m_busy});
      chk("mdl_dropped", {63'd0, Inc_Dropped}, {63'd0, m_drop});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          rst;
      bit          iv;
      int          ii;
      logic [31:0] ival;
      bit          ds;
      logic [31:0] e_cnt;
      bit          e_val;
      bit          e_last;
      bit          e_busy;
      bit          e_drop;
   } vec_t;

   vec_t tbl[$];

   function automatic void push(bit rst, bit iv, int ii, logic [31:0] ival, bit ds,
                                logic [31:0] e_cnt, bit e_val, bit e_last, bit e_busy, bit e_drop);
      vec_t v;
      v.rst = rst; v.iv = iv; v.ii = ii; v.ival = ival; v.ds = ds;
      v.e_cnt = e_cnt; v.e_val = e_val; v.e_last = e_last; v.e_busy = e_busy; v.e_drop = e_drop;
      tbl.push_back(v);
   endfunction

   logic [31:0] got [N];
   logic [31:0] exp2 [N];
   int vc, lc, dc;
   logic [63:0] sum;

   initial begin
      // Empty-array dump after reset.
      push(1, 0, 0, 32'd0, 0, 32'd0, 0, 0, 0, 0);
      push(0, 0, 0, 32'd0, 1, 32'd0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) push(0, 0, 0, 32'd0, 0, 32'd0, 1, (k == N - 1), 1, 0);
      push(0, 0, 0, 32'd0, 0, 32'd0, 0, 0, 0, 0);
      // Out-of-range indices 10 and 15: pulse, then quiet.
      push(0, 1, 10, 32'd5, 0, 32'd0, 0, 0, 0, 1);
      push(0, 0, 0, 32'd0, 0, 32'd0, 0, 0, 0, 0);
      push(0, 1, 15, 32'd9, 0, 32'd0, 0, 0, 0, 1);
      push(0, 0, 0, 32'd0, 0, 32'd0, 0, 0, 0, 0);
      // idx3 += 25, idx3 += 5, idx9 += 1, then dump twice.
      push(0, 1, 3, 32'd25, 0, 32'd0, 0, 0, 0, 0);
      push(0, 1, 3, 32'd5,  0, 32'd0, 0, 0, 0, 0);
      push(0, 1, 9, 32'd1,  0, 32'd0, 0, 0, 0, 0);
      push(0, 0, 0, 32'd0, 1, 32'd0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++)
         push(0, 0, 0, 32'd0, 0, (k == 3) ? 32'd30 : ((k == 9) ? 32'd1 : 32'd0), 1, (k == N - 1), 1, 0);
      push(0, 0, 0, 32'd0, 0, 32'd0, 0, 0, 0, 0);
      push(0, 0, 0, 32'd0, 1, 32'd0, 0, 0, 0, 0);
      for (int k = 0; k < N; k++) push(0, 0, 0, 32'd0, 0, 32'd0, 1, (k == N - 1), 1, 0);
      push(0, 0, 0, 32'd0, 0, 32'd0, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].iv, tbl[i].ii, tbl[i].ival, tbl[i].ds);
         chk($sformatf("tbl%0d_counter", i), {32'd0, Counter}, {32'd0, tbl[i].e_cnt});
         chk($sformatf("tbl%0d_valid", i), {63'd0, Counter_Valid}, {63'd0, tbl[i].e_val});
         chk($sformatf("tbl%0d_last", i), {63'd0, Frame_Last}, {63'd0, tbl[i].e_last});
         chk($sformatf("tbl%0d_busy", i), {63'd0, Busy}, {63'd0, tbl[i].e_busy});
         chk($sformatf("tbl%0d_dropped", i), {63'd0, Inc_Dropped}, {63'd0, tbl[i].e_drop});
      end

      // Saturation: 0xFFFFFFF0 + 0x20 must clamp to all ones.
      step(0, 1, 0, 32'hFFFF_FFF0, 0);
      step(0, 1, 0, 32'h0000_0020, 0);
      step(0, 0, 0, 32'd0, 1);
      step(0, 0, 0, 32'd0, 0);
      chk("sat_idx0", {32'd0, Counter}, 64'h0000_0000_FFFF_FFFF);
      for (int k = 1; k < N; k++) step(0, 0, 0, 32'd0, 0);
      step(0, 0, 0, 32'd0, 0);

      // Collisions during a frame: idx4 at its own read, idx2 behind the
      // pointer, idx8 ahead of it.
      step(0, 1, 4, 32'd11, 0);
      step(0, 1, 8, 32'd5, 0);
      step(0, 0, 0, 32'd0, 1);
      for (int k = 0; k < N; k++) begin
         if (k == 4)      step(0, 1, 4, 32'd7, 0);
         else if (k == 5) step(0, 1, 2, 32'd3, 0);
         else if (k == 6) step(0, 1, 8, 32'd2, 0);
         else             step(0, 0, 0, 32'd0, 0);
         got[k] = Counter;
      end
      chk("col_idx4_old", {32'd0, got[4]}, 64'd11);
      chk("col_idx8_inc", {32'd0, got[8]}, 64'd7);
      chk("col_idx2_old", {32'd0, got[2]}, 64'd0);
      step(0, 0, 0, 32'd0, 0);
      step(0, 0, 0, 32'd0, 1);
      for (int k = 0; k < N; k++) begin
         step(0, 0, 0, 32'd0, 0);
         got[k] = Counter;
         exp2[k] = (k == 2) ? 32'd3 : ((k == 4) ? 32'd7 : 32'd0);
      end
      for (int k = 0; k < N; k++) chk($sformatf("col_next_idx%0d", k), {32'd0, got[k]}, {32'd0, exp2[k]});
      step(0, 0, 0, 32'd0, 0);

      // Dump_Start re-pulsed mid-frame and an out-of-range increment.
      vc = 0; lc = 0; dc = 0;
      step(0, 0, 0, 32'd0, 1);
      for (int k = 0; k < N + 4; k++) begin
         step(0, (k == 5), 12, 32'd99, (k == 3));
         vc += int'(Counter_Valid);
         lc += int'(Frame_Last);
         dc += int'(Inc_Dropped);
      end
      chk("restart_len", vc, 64'd10);
      chk("restart_last", lc, 64'd1);
      chk("drop_pulses", dc, 64'd1);
      sum = 0;
      step(0, 0, 0, 32'd0, 1);
      for (int k = 0; k < N; k++) begin
         step(0, 0, 0, 32'd0, 0);
         sum += {32'd0, Counter};
      end
      chk("drop_no_change", sum, 64'd0);
      step(0, 0, 0, 32'd0, 0);

      // Reset at frame element 5, then a fresh dump must be empty.
      step(0, 1, 7, 32'd42, 0);
      step(0, 0, 0, 32'd0, 1);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 32'd0, 0);
      step(1, 0, 0, 32'd0, 0);
      chk("rst_counter", {32'd0, Counter}, 64'd0);
      chk("rst_valid", {63'd0, Counter_Valid}, 64'd0);
      chk("rst_last", {63'd0, Frame_Last}, 64'd0);
      chk("rst_busy", {63'd0, Busy}, 64'd0);
      step(0, 0, 0, 32'd0, 0);
      vc = 0; sum = 0;
      step(0, 0, 0, 32'd0, 1);
      for (int k = 0; k < N; k++) begin
         step(0, 0, 0, 32'd0, 0);
         vc += int'(Counter_Valid);
         sum += {32'd0, Counter};
      end
      chk("rst_dump_len", vc, 64'd10);
      chk("rst_dump_zero", sum, 64'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         bit          r_rst, r_iv, r_ds;
         int          r_ii;
         logic [31:0] r_val;
         r_rst = ($urandom_range(0, 99) == 0);
         r_iv  = ($urandom_range(0, 1) == 1);
         r_ii  = $urandom_range(0, 15);
         r_val = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1000));
         r_ds  = ($urandom_range(0, 9) == 0);
         step(r_rst, r_iv, r_ii, r_val, r_ds);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
